count_high_bit_stream: RTL and testbench

- Pipelined, streaming successor of the combinational high-bit counter, used in the EyeTracker pixel path.
- Counts set (or clear) bits of each valid input word with a fixed 2-cycle latency.
- Accumulates those counts over a framed group of words (line/frame/ROI), marked by first/last flags, for the center-of-gravity calculation.
- Reports a saturating group total with an overflow flag.

---
 rtl/count_high_bit_stream.sv | 174 +++++++++++++++++
 tb/tb_count_high_bit_stream.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/count_high_bit_stream.sv
// count_high_bit_stream
//
// Purpose:
//   Streaming, pipelined high-bit counter for the EyeTracker pixel path.
//   Each valid input word gets a popcount of its set bits (iMODE=0) or its
//   clear bits (iMODE=1). The result appears exactly two cycles after the
//   word is presented. Counts of words framed by iFIRST/iLAST are summed
//   into a saturating group total, which feeds the center-of-gravity
//   calculation.
//
// Ports:
//   iCLK         clock, rising edge
//   iRST_N       asynchronous active-low reset
//   iVALID       qualifies iBIT/iFIRST/iLAST/iMODE (no backpressure)
//   iBIT         data word, BIT_WIDTH bits
//   iFIRST       word opens a group
//   iLAST        word closes a group
//   iMODE        0 = count ones, 1 = count zeros
//   oWORD_VALID  per-word result strobe
//   oWORD_COUNT  per-word count, $clog2(BIT_WIDTH)+1 bits
//   oACC_VALID   one-cycle group-complete strobe
//   oACC_COUNT   saturating group total, held between strobes
//   oACC_OVF     group saturated, held with oACC_COUNT
//   oDROP        one-cycle pulse: an open group was discarded by a new iFIRST

module count_high_bit_stream #(
  parameter int BIT_WIDTH   = 32,
  parameter int CHUNK_WIDTH = 8,
  parameter int ACC_WIDTH   = 20
) (
  input  logic                         iCLK,
  input  logic                         iRST_N,
  input  logic                         iVALID,
  input  logic [BIT_WIDTH-1:0]         iBIT,
  input  logic                         iFIRST,
  input  logic                         iLAST,
  input  logic                         iMODE,
  output logic                         oWORD_VALID,
  output logic [$clog2(BIT_WIDTH):0]   oWORD_COUNT,
  output logic                         oACC_VALID,
  output logic [ACC_WIDTH-1:0]         oACC_COUNT,
  output logic                         oACC_OVF,
  output logic                         oDROP
);

  localparam int CNT_WIDTH   = $clog2(BIT_WIDTH) + 1;
  localparam int NUM_CHUNKS  = (BIT_WIDTH + CHUNK_WIDTH - 1) / CHUNK_WIDTH;
  localparam int CHUNK_CNT_W = $clog2(CHUNK_WIDTH) + 1;
  localparam int PAD_WIDTH   = NUM_CHUNKS * CHUNK_WIDTH;
  localparam int SUM_WIDTH   = ACC_WIDTH + 1;

  typedef enum logic {
    CLOSED = 1'b0,
    OPEN   = 1'b1
  } state_t;

  logic [BIT_WIDTH-1:0]   mode_word;
  logic [PAD_WIDTH-1:0]   padded;
  logic [CHUNK_CNT_W-1:0] chunk_acc;
  logic [CHUNK_CNT_W-1:0] chunk_cnt [NUM_CHUNKS];

  logic [CHUNK_CNT_W-1:0] s1_cnt [NUM_CHUNKS];
  logic                   s1_valid;
  logic                   s1_first;
  logic                   s1_last;

  logic [CNT_WIDTH-1:0]   word_cnt;
  logic [SUM_WIDTH-1:0]   sum_ext;
  logic [ACC_WIDTH-1:0]   next_acc;
  logic                   next_ovf;

  state_t                 state;
  logic [ACC_WIDTH-1:0]   acc;
  logic                   ovf;

  // Stage 1 combinational: the mode inversion happens before padding, so
  // the zero fill of a partial last chunk is never counted in either mode.
  always_comb begin
    mode_word = iMODE ? ~iBIT : iBIT;
    padded = '0;
    padded[BIT_WIDTH-1:0] = mode_word;
    chunk_acc = '0;
    for (int i = 0; i < NUM_CHUNKS; i++) begin
      chunk_acc = '0;
      for (int j = 0; j < CHUNK_WIDTH; j++) begin
        chunk_acc = chunk_acc + CHUNK_CNT_W'(padded[i*CHUNK_WIDTH + j]);
      end
      chunk_cnt[i] = chunk_acc;
    end
  end

  // Stage 1 registers: partial counts plus the qualified framing flags.
  // Flags are masked with iVALID so idle cycles can never frame a group.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      for (int i = 0; i < NUM_CHUNKS; i++) begin
        s1_cnt[i] <= '0;
      end
    end else begin
      s1_valid <= iVALID;
      s1_first <= iVALID & iFIRST;
      s1_last  <= iVALID & iLAST;
      if (iVALID) begin
        for (int i = 0; i < NUM_CHUNKS; i++) begin
          s1_cnt[i] <= chunk_cnt[i];
        end
      end
    end
  end

  // Stage 2 combinational: word total and the candidate group total.
  // A first word restarts the group; otherwise add with saturation, and the
  // carry out of the widened sum marks the overflow.
  always_comb begin
    word_cnt = '0;
    for (int i = 0; i < NUM_CHUNKS; i++) begin
      word_cnt = word_cnt + CNT_WIDTH'(s1_cnt[i]);
    end
    sum_ext = {1'b0, acc} + SUM_WIDTH'(word_cnt);
    if (s1_first) begin
      next_acc = ACC_WIDTH'(word_cnt);
      next_ovf = 1'b0;
    end else if (sum_ext[ACC_WIDTH]) begin
      next_acc = '1;
      next_ovf = 1'b1;
    end else begin
      next_acc = sum_ext[ACC_WIDTH-1:0];
      next_ovf = ovf;
    end
  end

  // Stage 2 registers and group state machine. Accumulation and reporting
  // share this stage, so the group strobe lines up with the last word's
  // own result strobe and no extra cycle is spent.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state       <= CLOSED;
      acc         <= '0;
      ovf         <= 1'b0;
      oWORD_VALID <= 1'b0;
      oWORD_COUNT <= '0;
      oACC_VALID  <= 1'b0;
      oACC_COUNT  <= '0;
      oACC_OVF    <= 1'b0;
      oDROP       <= 1'b0;
    end else begin
      oWORD_VALID <= s1_valid;
      oACC_VALID  <= 1'b0;
      oDROP       <= 1'b0;
      if (s1_valid) begin
        oWORD_COUNT <= word_cnt;
        if (s1_first || state == OPEN) begin
          acc <= next_acc;
          ovf <= next_ovf;
        end
        if (s1_first && state == OPEN) begin
          oDROP <= 1'b1;
        end
        if (s1_last && (s1_first || state == OPEN)) begin
          oACC_VALID <= 1'b1;
          oACC_COUNT <= next_acc;
          oACC_OVF   <= next_ovf;
          state      <= CLOSED;
        end else if (s1_first) begin
          state <= OPEN;
        end
      end
    end
  end

endmodule

// File: tb/tb_count_high_bit_stream.sv
// tb_count_high_bit_stream
//
// Purpose:
//   Self-checking bench for count_high_bit_stream. A directed vector table
//   drives the default 32-bit instance; hand-written sequences cover the
//   12-bit padded instance, a 6-bit saturating accumulator instance, and an
//   asynchronous reset in the middle of a group.
//
// Ports: none (top-level bench).

module tb_count_high_bit_stream;

  logic        clk;
  logic        rst_n;

  logic        valid;
  logic [31:0] data;
  logic        first;
  logic        last;
  logic        mode;

  logic        nar_valid;
  logic [11:0] nar_data;
  logic        nar_first;
  logic        nar_last;
  logic        nar_mode;

  logic        m_wv;
  logic [5:0]  m_wc;
  logic        m_av;
  logic [19:0] m_ac;
  logic        m_ao;
  logic        m_dr;

  logic        n_wv;
  logic [4:0]  n_wc;
  logic        n_av;
  logic [19:0] n_ac;
  logic        n_ao;
  logic        n_dr;

  logic        s_wv;
  logic [5:0]  s_wc;
  logic        s_av;
  logic [5:0]  s_ac;
  logic        s_ao;
  logic        s_dr;

  int total;
  int bad;

  typedef struct packed {
    logic        v;
    logic [31:0] data;
    logic        f;
    logic        l;
    logic        m;
    logic        e_wv;
    logic [5:0]  e_wc;
    logic        e_av;
    logic [19:0] e_ac;
    logic        e_ao;
    logic        e_dr;
  } vec_t;

  localparam int NUM_VECS = 17;
  vec_t vecs [NUM_VECS];

  count_high_bit_stream #(.BIT_WIDTH(32), .CHUNK_WIDTH(8), .ACC_WIDTH(20)) u_main (
    .iCLK(clk), .iRST_N(rst_n), .iVALID(valid), .iBIT(data),
    .iFIRST(first), .iLAST(last), .iMODE(mode),
    .oWORD_VALID(m_wv), .oWORD_COUNT(m_wc), .oACC_VALID(m_av),
    .oACC_COUNT(m_ac), .oACC_OVF(m_ao), .oDROP(m_dr)
  );

  count_high_bit_stream #(.BIT_WIDTH(12), .CHUNK_WIDTH(8), .ACC_WIDTH(20)) u_narrow (
    .iCLK(clk), .iRST_N(rst_n), .iVALID(nar_valid), .iBIT(nar_data),
    .iFIRST(nar_first), .iLAST(nar_last), .iMODE(nar_mode),
    .oWORD_VALID(n_wv), .oWORD_COUNT(n_wc), .oACC_VALID(n_av),
    .oACC_COUNT(n_ac), .oACC_OVF(n_ao), .oDROP(n_dr)
  );

  count_high_bit_stream #(.BIT_WIDTH(32), .CHUNK_WIDTH(8), .ACC_WIDTH(6)) u_sat (
    .iCLK(clk), .iRST_N(rst_n), .iVALID(valid), .iBIT(data),
    .iFIRST(first), .iLAST(last), .iMODE(mode),
    .oWORD_VALID(s_wv), .oWORD_COUNT(s_wc), .oACC_VALID(s_av),
    .oACC_COUNT(s_ac), .oACC_OVF(s_ao), .oDROP(s_dr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of the shared 32-bit inputs, then step to the next
  // falling edge where outputs are sampled.
  task automatic apply_stimulus(input logic v, input logic [31:0] d,
                                input logic f, input logic l, input logic m);
    valid = v;
    data  = d;
    first = f;
    last  = l;
    mode  = m;
    @(negedge clk);
  endtask

  task automatic check_main_row(input int idx);
    string tag;
    tag = $sformatf("row%0d", idx);
    check_output({tag, " word_valid"}, 32'(m_wv), 32'(vecs[idx].e_wv));
    if (vecs[idx].e_wv) begin
      check_output({tag, " word_count"}, 32'(m_wc), 32'(vecs[idx].e_wc));
    end
    check_output({tag, " acc_valid"}, 32'(m_av), 32'(vecs[idx].e_av));
    check_output({tag, " acc_count"}, 32'(m_ac), 32'(vecs[idx].e_ac));
    check_output({tag, " acc_ovf"}, 32'(m_ao), 32'(vecs[idx].e_ao));
    check_output({tag, " drop"}, 32'(m_dr), 32'(vecs[idx].e_dr));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    valid = 1'b0; data = '0; first = 1'b0; last = 1'b0; mode = 1'b0;
    nar_valid = 1'b0; nar_data = '0; nar_first = 1'b0; nar_last = 1'b0; nar_mode = 1'b0;

    // Expected results for each row appear two cycles after the row is driven.
    //            v     data          f     l     m     wv    wc     av    ac        ovf   drop
    vecs[0]  = '{1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0,  1'b0, 20'd0,  1'b0, 1'b0};
    vecs[1]  = '{1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 6'd32, 1'b0, 20'd0,  1'b0, 1'b0};
    vecs[2]  = '{1'b1, 32'h80000001, 1'b0, 1'b0, 1'b0, 1'b1, 6'd2,  1'b0, 20'd0,  1'b0, 1'b0};
    vecs[3]  = '{1'b1, 32'h0000FFFF, 1'b0, 1'b0, 1'b1, 1'b1, 6'd16, 1'b0, 20'd0,  1'b0, 1'b0};
    vecs[4]  = '{1'b1, 32'h0000000F, 1'b1, 1'b0, 1'b0, 1'b1, 6'd4,  1'b0, 20'd0,  1'b0, 1'b0};
    vecs[5]  = '{1'b1, 32'h000000FF, 1'b0, 1'b0, 1'b0, 1'b1, 6'd8,  1'b0, 20'd0,  1'b0, 1'b0};
    vecs[6]  = '{1'b0, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0,  1'b0, 20'd0,  1'b0, 1'b0};
    vecs[7]  = '{1'b1, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1'b1, 6'd32, 1'b1, 20'd44, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 20'd44, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 32'h00000003, 1'b0, 1'b1, 1'b0, 1'b1, 6'd2,  1'b0, 20'd44, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 32'h00000007, 1'b0, 1'b0, 1'b0, 1'b1, 6'd3,  1'b0, 20'd44, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 32'h00000001, 1'b1, 1'b0, 1'b0, 1'b1, 6'd1,  1'b0, 20'd44, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 32'h00000003, 1'b0, 1'b0, 1'b0, 1'b1, 6'd2,  1'b0, 20'd44, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 32'h0000000F, 1'b1, 1'b0, 1'b0, 1'b1, 6'd4,  1'b0, 20'd44, 1'b0, 1'b1};
    vecs[14] = '{1'b1, 32'h000000FF, 1'b0, 1'b1, 1'b0, 1'b1, 6'd8,  1'b1, 20'd12, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 32'h00000001, 1'b1, 1'b1, 1'b1, 1'b1, 6'd31, 1'b1, 20'd31, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1, 1'b1, 6'd0,  1'b0, 20'd31, 1'b0, 1'b0};

    // Reset state
    #7;
    check_output("reset word_valid", 32'(m_wv), 32'd0);
    check_output("reset word_count", 32'(m_wc), 32'd0);
    check_output("reset acc_valid", 32'(m_av), 32'd0);
    check_output("reset acc_count", 32'(m_ac), 32'd0);
    check_output("reset acc_ovf", 32'(m_ao), 32'd0);
    check_output("reset drop", 32'(m_dr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table: row k-2 is checked at the sampling edge where row k is driven
    for (int k = 0; k < NUM_VECS + 2; k++) begin
      if (k >= 2) begin
        check_main_row(k - 2);
      end
      if (k < NUM_VECS) begin
        apply_stimulus(vecs[k].v, vecs[k].data, vecs[k].f, vecs[k].l, vecs[k].m);
      end else begin
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      end
    end

    // 12-bit word: padding of the partial chunk must not count as zeros
    nar_valid = 1'b1; nar_data = 12'h000; nar_mode = 1'b1;
    @(negedge clk);
    nar_data = 12'hFFF;
    @(negedge clk);
    check_output("narrow zeros of 000 valid", 32'(n_wv), 32'd1);
    check_output("narrow zeros of 000", 32'(n_wc), 32'd12);
    nar_data = 12'h801;
    @(negedge clk);
    check_output("narrow zeros of FFF", 32'(n_wc), 32'd0);
    nar_valid = 1'b0; nar_data = 12'h000; nar_mode = 1'b0;
    @(negedge clk);
    check_output("narrow zeros of 801", 32'(n_wc), 32'd10);
    @(negedge clk);
    check_output("narrow idle word_valid", 32'(n_wv), 32'd0);

    // Saturating 6-bit accumulator, then a single-word group clears overflow
    apply_stimulus(1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0);
    apply_stimulus(1'b1, 32'h00000001, 1'b1, 1'b1, 1'b0);
    check_output("sat acc_valid", 32'(s_av), 32'd1);
    check_output("sat acc_count", 32'(s_ac), 32'd63);
    check_output("sat acc_ovf", 32'(s_ao), 32'd1);
    check_output("wide acc_count 96", 32'(m_ac), 32'd96);
    check_output("wide acc_ovf", 32'(m_ao), 32'd0);
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check_output("sat single acc_valid", 32'(s_av), 32'd1);
    check_output("sat single acc_count", 32'(s_ac), 32'd1);
    check_output("sat single acc_ovf", 32'(s_ao), 32'd0);
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check_output("sat hold acc_valid", 32'(s_av), 32'd0);
    check_output("sat hold acc_count", 32'(s_ac), 32'd1);

    // Asynchronous reset with an open group and words in flight
    apply_stimulus(1'b1, 32'h000000FF, 1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b1, 32'h0000FFFF, 1'b0, 1'b0, 1'b0);
    check_output("pre-reset word_valid", 32'(m_wv), 32'd1);
    check_output("pre-reset acc_count", 32'(m_ac), 32'd1);
    valid = 1'b1; data = 32'hFFFFFFFF; first = 1'b0; last = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_output("mid reset word_valid", 32'(m_wv), 32'd0);
    check_output("mid reset word_count", 32'(m_wc), 32'd0);
    check_output("mid reset acc_count", 32'(m_ac), 32'd0);
    check_output("mid reset acc_ovf", 32'(m_ao), 32'd0);
    check_output("mid reset acc_valid", 32'(m_av), 32'd0);
    @(negedge clk);
    valid = 1'b0; data = '0; last = 1'b0;
    rst_n = 1'b1;
    apply_stimulus(1'b1, 32'h00000003, 1'b0, 1'b1, 1'b0);
    check_output("post reset flushed word_valid", 32'(m_wv), 32'd0);
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check_output("post reset stray word_valid", 32'(m_wv), 32'd1);
    check_output("post reset stray word_count", 32'(m_wc), 32'd2);
    check_output("post reset stray acc_valid", 32'(m_av), 32'd0);
    check_output("post reset acc_count", 32'(m_ac), 32'd0);
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check_output("post reset idle acc_valid", 32'(m_av), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
